// File: rtl/corr_peak_detect.sv
// Sliding-window correlation/energy peak detector: windowed sums, ratio test against
// a Q0.8 threshold, and a confirm/holdoff FSM that emits a one-cycle detect pulse.
module corr_peak_detect #(
    parameter int  DATAWIDTH = 16,
    parameter int  WINDOW    = 8,
    parameter int  HOLD_CNT  = 4,
    parameter int  HOLDOFF   = 64,
    localparam int ACCW      = DATAWIDTH + $clog2(WINDOW)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic signed [DATAWIDTH-1:0] corr_i,
    input  logic signed [DATAWIDTH-1:0] energy_i,
    input  logic                        valid_i,
    input  logic [7:0]                  thresh_i,
    input  logic                        enable_i,
    output logic                        detect_o,
    output logic                        metric_valid_o,
    output logic signed [ACCW-1:0]      corr_acc_o,
    output logic signed [ACCW-1:0]      energy_acc_o,
    output logic [2:0]                  state_o
);

    localparam int CMPW  = ACCW + 9;
    localparam int FILLW = $clog2(WINDOW) + 1;
    localparam int RUNW  = $clog2(HOLD_CNT + 1);
    localparam int HOFW  = $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL    = 3'd1,
        S_SEARCH  = 3'd2,
        S_CONFIRM = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [RUNW-1:0] run_q, run_d;
    logic [HOFW-1:0] hold_q, hold_d;
    logic            detect_q, detect_d;

    logic start;
    logic accept;

    logic signed [DATAWIDTH-1:0] energy_clamp;
    logic signed [DATAWIDTH-1:0] corr_dl   [WINDOW];
    logic signed [DATAWIDTH-1:0] energy_dl [WINDOW];

    logic signed [ACCW-1:0] corr_acc_q, energy_acc_q;
    logic signed [ACCW-1:0] corr_new, energy_new, corr_old, energy_old;
    logic [FILLW-1:0]       fill_q;
    logic                   metric_valid_q;

    logic                   upd_q, strobe_q, above_q, above_d;
    logic signed [CMPW-1:0] cmp_lhs, cmp_rhs;

    // Leaving IDLE restarts the window from empty; IDLE itself never samples.
    assign start  = (state_q == S_IDLE) && enable_i;
    assign accept = valid_i && enable_i && (state_q != S_IDLE);

    assign energy_clamp = energy_i[DATAWIDTH-1] ? '0 : energy_i;

    assign corr_new   = {{(ACCW-DATAWIDTH){corr_i[DATAWIDTH-1]}}, corr_i};
    assign energy_new = {{(ACCW-DATAWIDTH){1'b0}}, energy_clamp};
    assign corr_old   = {{(ACCW-DATAWIDTH){corr_dl[WINDOW-1][DATAWIDTH-1]}}, corr_dl[WINDOW-1]};
    assign energy_old = {{(ACCW-DATAWIDTH){1'b0}}, energy_dl[WINDOW-1]};

    // NOTE: the delay line is reset and cleared like any other register because the
    // oldest entry is subtracted from the sums; stale contents would corrupt them.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, whatever the block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < WINDOW; i++) begin
                corr_dl[i]   <= '0;
                energy_dl[i] <= '0;
            end
        end else if (start) begin
            for (int i = 0; i < WINDOW; i++) begin
                corr_dl[i]   <= '0;
                energy_dl[i] <= '0;
            end
        end else if (accept) begin
            corr_dl[0]   <= corr_i;
            energy_dl[0] <= energy_clamp;
            for (int i = 1; i < WINDOW; i++) begin
                corr_dl[i]   <= corr_dl[i-1];
                energy_dl[i] <= energy_dl[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            corr_acc_q     <= '0;
            energy_acc_q   <= '0;
            fill_q         <= '0;
            metric_valid_q <= 1'b0;
        end else if (start) begin
            corr_acc_q     <= '0;
            energy_acc_q   <= '0;
            fill_q         <= '0;
            metric_valid_q <= 1'b0;
        end else if (accept) begin
            corr_acc_q     <= corr_acc_q + corr_new - corr_old;
            energy_acc_q   <= energy_acc_q + energy_new - energy_old;
            fill_q         <= (fill_q == FILLW'(WINDOW)) ? fill_q : fill_q + 1'b1;
            metric_valid_q <= metric_valid_q || (fill_q == FILLW'(WINDOW - 1));
        end
    end

    // corr/energy >= thresh/256, evaluated without division on ACCW+9 signed operands.
    assign cmp_lhs = {corr_acc_q[ACCW-1], corr_acc_q, 8'b0};
    assign cmp_rhs = $signed({{9{energy_acc_q[ACCW-1]}}, energy_acc_q})
                   * $signed({{(ACCW+1){1'b0}}, thresh_i});
    assign above_d = !corr_acc_q[ACCW-1] && (corr_acc_q != '0) && (cmp_lhs >= cmp_rhs);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            upd_q    <= 1'b0;
            strobe_q <= 1'b0;
            above_q  <= 1'b0;
        end else begin
            upd_q    <= accept;
            strobe_q <= upd_q && metric_valid_q;
            if (upd_q && metric_valid_q) begin
                above_q <= above_d;
            end
        end
    end

    // NOTE: every always_comb target gets a default before the case, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        hold_d   = hold_q;
        detect_d = 1'b0;
        if (!enable_i) begin
            state_d = S_IDLE;
            run_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FILL;
                    run_d   = '0;
                end
                S_FILL: begin
                    if (metric_valid_q) state_d = S_SEARCH;
                end
                S_SEARCH: begin
                    if (strobe_q && above_q) begin
                        if (HOLD_CNT == 1) begin
                            detect_d = 1'b1;
                            run_d    = '0;
                            hold_d   = '0;
                            state_d  = S_HOLDOFF;
                        end else begin
                            run_d   = RUNW'(1);
                            state_d = S_CONFIRM;
                        end
                    end
                end
                S_CONFIRM: begin
                    if (strobe_q) begin
                        if (!above_q) begin
                            run_d   = '0;
                            state_d = S_SEARCH;
                        end else if (run_q == RUNW'(HOLD_CNT - 1)) begin
                            detect_d = 1'b1;
                            run_d    = '0;
                            hold_d   = '0;
                            state_d  = S_HOLDOFF;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (hold_q == HOFW'(HOLDOFF - 1)) begin
                        hold_d  = '0;
                        state_d = S_SEARCH;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            run_q    <= '0;
            hold_q   <= '0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            hold_q   <= hold_d;
            detect_q <= detect_d;
        end
    end

    assign detect_o       = detect_q;
    assign metric_valid_o = metric_valid_q;
    assign corr_acc_o     = corr_acc_q;
    assign energy_acc_o   = energy_acc_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_corr_peak_detect.sv
// Scoreboard bench for corr_peak_detect: a window/ratio/run-length reference model
// queues expected sums and detect times; a negedge monitor compares them.
module tb_corr_peak_detect;

    localparam int DW   = 16;
    localparam int W    = 8;
    localparam int HC   = 4;
    localparam int HO   = 64;
    localparam int ACCW = DW + $clog2(W);

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic signed [DW-1:0]   corr_i, energy_i;
    logic                   valid_i, enable_i;
    logic [7:0]             thresh_i;
    logic                   detect_o, metric_valid_o;
    logic signed [ACCW-1:0] corr_acc_o, energy_acc_o;
    logic [2:0]             state_o;

    corr_peak_detect #(.DATAWIDTH(DW), .WINDOW(W), .HOLD_CNT(HC), .HOLDOFF(HO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .corr_i(corr_i), .energy_i(energy_i),
        .valid_i(valid_i), .thresh_i(thresh_i), .enable_i(enable_i),
        .detect_o(detect_o), .metric_valid_o(metric_valid_o),
        .corr_acc_o(corr_acc_o), .energy_acc_o(energy_acc_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int bound);
        n_checks++;
        if (!(act >= bound)) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected at least %0d (edge %0d)", name, act, bound, cyc);
        end
    endtask

    // Reference model: spec state numbering, window as a queue of recent samples,
    // holdoff as an absolute end edge, evaluations as timestamped events.
    typedef struct {int k; longint c; longint e; bit mv;} acc_exp_t;
    acc_exp_t acc_q[$];
    int       det_q[$];
    int       det_seen[$];
    acc_exp_t mon_x;

    int qc[$], qe[$];
    int ms, m_run, m_hold_end, m_str_edge, m_full_edge, m_cnt;
    bit m_mv, m_str_above;
    int cur_th;

    function automatic longint qsum(input int q[$]);
        longint s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic m_reset();
        qc.delete(); qe.delete();
        ms = 0; m_run = 0; m_hold_end = -1000; m_str_edge = -1000;
        m_full_edge = -1000; m_cnt = 0; m_mv = 0; m_str_above = 0;
        acc_q.delete(); det_q.delete();
    endtask

    // Advance the model across edge k with the inputs sampled at that edge.
    task automatic m_step(input int k, input bit en, input bit v, input int c,
                          input int e, input int th);
        bit     strobe, ab, det;
        int     ns;
        longint sc, se;
        strobe = (m_str_edge == k - 1);
        ab     = m_str_above;
        det    = 0;
        ns     = ms;
        if (!en) begin
            ns = 0; m_run = 0;
        end else begin
            case (ms)
                0: ns = 1;
                1: if (m_mv) ns = 2;
                2: if (strobe && ab) begin
                       if (HC == 1) det = 1;
                       else begin m_run = 1; ns = 3; end
                   end
                3: if (strobe) begin
                       if (ab) begin
                           m_run++;
                           if (m_run == HC) begin det = 1; m_run = 0; end
                       end else begin
                           m_run = 0; ns = 2;
                       end
                   end
                4: if (k == m_hold_end) ns = 2;
                default: ns = 0;
            endcase
        end
        if (det) begin
            det_q.push_back(k);
            ns = 4;
            m_hold_end = k + HO;
        end
        sc = qsum(qc);
        se = qsum(qe);
        if (m_full_edge == k - 1) begin
            m_str_edge  = k;
            m_str_above = (sc > 0) && (sc * 256 >= se * th);
        end
        if (ms == 0 && en) begin
            qc.delete(); qe.delete(); m_cnt = 0; m_mv = 0;
        end else if (en && v && ms != 0) begin
            qc.push_back(c);
            qe.push_back(e < 0 ? 0 : e);
            if (qc.size() > W) begin
                void'(qc.pop_front());
                void'(qe.pop_front());
            end
            m_cnt++;
            if (m_cnt >= W) m_mv = 1;
            if (m_mv) m_full_edge = k;
            acc_q.push_back('{k, qsum(qc), qsum(qe), m_mv});
        end
        ms = ns;
    endtask

    task automatic drive(input bit en, input bit v, input int c, input int e);
        enable_i = en;
        valid_i  = v;
        corr_i   = 16'(c);
        energy_i = 16'(e);
        thresh_i = 8'(cur_th);
        m_step(cyc + 1, en, v, c, e, cur_th);
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (acc_q.size() > 0 && acc_q[0].k == cyc) begin
                mon_x = acc_q.pop_front();
                check("corr_acc", corr_acc_o, mon_x.c);
                check("energy_acc", energy_acc_o, mon_x.e);
                check("metric_valid", metric_valid_o, mon_x.mv);
            end
            if (detect_o === 1'b1) begin
                det_seen.push_back(cyc);
                if (det_q.size() == 0) check("unexpected_detect", 1, 0);
                else check("detect_edge", cyc, det_q.pop_front());
            end else if (det_q.size() > 0 && det_q[0] <= cyc) begin
                check("missed_detect", cyc, det_q.pop_front());
            end
        end
    end

    initial begin
        int k11, lat, n0, vprob, cbase, ebase, rc, re;
        bit ren, rv;

        rst_ni = 1'b0; enable_i = 1'b0; valid_i = 1'b0;
        corr_i = '0; energy_i = '0; cur_th = 8'h80; thresh_i = 8'h80;
        m_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_detect", detect_o, 0);
        check("rst_metric_valid", metric_valid_o, 0);
        check("rst_corr_acc", corr_acc_o, 0);
        check("rst_energy_acc", energy_acc_o, 0);
        check("rst_state", state_o, 0);
        rst_ni = 1'b1;

        // Fill, then continuous equal corr/energy: first detect and holdoff spacing.
        drive(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) drive(1, 1, 'h2000, 'h2000);
        check("fill_state", state_o, 1);
        check("fill_not_valid", metric_valid_o, 0);
        drive(1, 1, 'h2000, 'h2000);
        check("full_valid", metric_valid_o, 1);
        check("full_corr_acc", corr_acc_o, 'h10000);
        check("full_energy_acc", energy_acc_o, 'h10000);
        drive(1, 1, 'h2000, 'h2000);
        drive(1, 1, 'h2000, 'h2000);
        k11 = cyc + 1;
        drive(1, 1, 'h2000, 'h2000);
        lat = -1;
        for (int i = 0; i < 10 && lat < 0; i++) begin
            drive(1, 1, 'h2000, 'h2000);
            if (detect_o === 1'b1) begin
                lat = cyc - (k11 - 1);
                check("holdoff_state", state_o, 4);
            end
        end
        check("detect_latency", lat, 3);
        n0 = det_seen.size();
        for (int i = 0; i < 220; i++) drive(1, 1, 'h2000, 'h2000);
        check_ge("pulse_count", det_seen.size() - n0 + 1, 3);
        for (int i = (n0 > 0 ? n0 : 1); i < det_seen.size(); i++)
            check_ge("detect_spacing", det_seen[i] - det_seen[i-1], HO + HC);

        // Ratio 0.25 stays below 0.5.
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        n0 = det_seen.size();
        for (int i = 0; i < 200; i++) drive(1, 1, 'h0800, 'h2000);
        check("low_ratio_no_detect", det_seen.size() - n0, 0);
        check("low_ratio_state", state_o, 2);

        // Three above, one below (threshold nudged), four above: one detect.
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        n0 = det_seen.size();
        for (int i = 1; i <= 17; i++) begin
            cur_th = (i == 12) ? 'h81 : 'h80;
            drive(1, 1, 'h1000, 'h2000);
        end
        cur_th = 'h80;
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0);
        check("broken_run_detects", det_seen.size() - n0, 1);

        // Reset asserted while confirming.
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(1, 1, 'h2000, 'h2000);
        check("confirm_state", state_o, 3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_detect", detect_o, 0);
        check("midrst_metric_valid", metric_valid_o, 0);
        check("midrst_corr_acc", corr_acc_o, 0);
        check("midrst_energy_acc", energy_acc_o, 0);
        check("midrst_state", state_o, 0);
        m_reset();
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Negative correlation never detects.
        drive(1, 0, 0, 0);
        n0 = det_seen.size();
        for (int i = 0; i < 100; i++) drive(1, 1, -'h2000, 'h2000);
        check("neg_corr_no_detect", det_seen.size() - n0, 0);
        check("neg_corr_state", state_o, 2);

        // Randomized phases: varying bias, valid density, threshold and enable drops.
        for (int ph = 0; ph < 14; ph++) begin
            cur_th = $urandom_range(0, 200);
            vprob  = $urandom_range(30, 100);
            cbase  = int'($urandom_range(0, 'h3000)) - 'h0c00;
            ebase  = int'($urandom_range(0, 'h3000)) - 'h0400;
            for (int i = 0; i < 200; i++) begin
                ren = ($urandom_range(0, 299) != 0);
                rv  = ($urandom_range(1, 100) <= vprob);
                rc  = cbase + int'($urandom_range(0, 'h0800)) - 'h0400;
                re  = ebase + int'($urandom_range(0, 'h0800)) - 'h0400;
                if ($urandom_range(0, 49) == 0) cur_th = $urandom_range(0, 255);
                drive(ren, rv, rc, re);
            end
        end

        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0);
        check("detect_queue_drained", det_q.size(), 0);
        check("acc_queue_drained", acc_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
